// File: rtl/cic_pkg.sv
// Shared definitions for the I/Q CIC decimator.
//   cic_state_e : output sequencer states (IDLE, COMB_I, COMB_Q)
//   acc_width() : internal accumulator width. Integrator growth is
//                 N_STAGES*RBITS bits above the sample width, so the
//                 modulo-2**ACC_W arithmetic never loses the in-band result.
package cic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMB_I = 2'd1,
    COMB_Q = 2'd2
  } cic_state_e;

  function automatic int acc_width(input int dw, input int n_stages, input int rbits);
    return dw + n_stages * rbits;
  endfunction

endpackage

// File: rtl/cic_integrator_chain.sv
// Cascade of N_STAGES integrators for one channel.
//   clk, rst        : clock, asynchronous active-high reset
//   enable          : advance every stage by one sample this cycle
//   sample          : sign-extended input sample (ACC_W bits)
//   last_stage      : registered value of the final integrator
//   last_stage_next : value the final integrator takes if enable is high now
// Each stage adds the *registered* value of the stage before it, so the
// cascade is fully pipelined; arithmetic wraps modulo 2**ACC_W by design.
module cic_integrator_chain
  import cic_pkg::*;
#(
  parameter int ACC_W    = 22,
  parameter int N_STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [ACC_W-1:0] sample,
  output logic [ACC_W-1:0] last_stage,
  output logic [ACC_W-1:0] last_stage_next
);

  logic [ACC_W-1:0] acc      [N_STAGES];
  logic [ACC_W-1:0] acc_next [N_STAGES];

  always_comb begin
    acc_next[0] = acc[0] + sample;
    for (int k = 1; k < N_STAGES; k++) begin
      acc_next[k] = acc[k] + acc[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_STAGES; k++) begin
        acc[k] <= '0;
      end
    end else if (enable) begin
      for (int k = 0; k < N_STAGES; k++) begin
        acc[k] <= acc_next[k];
      end
    end
  end

  assign last_stage      = acc[N_STAGES-1];
  assign last_stage_next = acc_next[N_STAGES-1];

endmodule

// File: rtl/iq_cic_decimator.sv
// Decimating CIC low-pass filter for an interleaved I/Q stream.
//   clk, rst : clock, asynchronous active-high reset
//   data_i   : signed input sample (I or Q)
//   valid_i  : data_i carries a sample this cycle
//   last_i   : with valid_i, 1 = Q sample, 0 = I sample
//   data_o   : signed decimated output sample
//   valid_o  : data_o carries a sample this cycle
//   last_o   : with valid_o, 1 = Q output, 0 = I output
//
// Handshake: valid-only, no ready in either direction. A sample is taken on
// every clock edge where valid_i is high; the consumer must take data_o on
// every edge where valid_o is high. Outputs always come as an I then Q pair
// on consecutive cycles.
//
// Every R-th Q sample (R = 2**RBITS) snapshots both channels' final
// integrators. The sequencer then runs the I snapshot and the Q snapshot
// through one shared comb datapath on two successive cycles, each channel
// keeping its own comb delay registers.
module iq_cic_decimator
  import cic_pkg::*;
#(
  parameter int DW       = 16,
  parameter int N_STAGES = 3,
  parameter int RBITS    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_i,
  input  logic          valid_i,
  input  logic          last_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  output logic          last_o
);

  localparam int ACC_W = acc_width(DW, N_STAGES, RBITS);
  localparam int SHIFT = N_STAGES * RBITS;
  localparam logic [RBITS-1:0] CNT_LAST = '1;  // R-1

  logic [ACC_W-1:0] sample_ext;
  logic             i_en;
  logic             q_en;
  logic             dec_edge;
  logic [RBITS-1:0] dec_cnt;

  logic [ACC_W-1:0] i_last, i_next, i_post;
  logic [ACC_W-1:0] q_last, q_next, q_post;
  logic [ACC_W-1:0] snap_i, snap_q;

  cic_state_e state, state_next;

  assign sample_ext = {{(ACC_W-DW){data_i[DW-1]}}, data_i};
  assign i_en       = valid_i & ~last_i;
  assign q_en       = valid_i &  last_i;
  assign dec_edge   = q_en && (dec_cnt == CNT_LAST);

  cic_integrator_chain #(
    .ACC_W    (ACC_W),
    .N_STAGES (N_STAGES)
  ) u_int_i (
    .clk             (clk),
    .rst             (rst),
    .enable          (i_en),
    .sample          (sample_ext),
    .last_stage      (i_last),
    .last_stage_next (i_next)
  );

  cic_integrator_chain #(
    .ACC_W    (ACC_W),
    .N_STAGES (N_STAGES)
  ) u_int_q (
    .clk             (clk),
    .rst             (rst),
    .enable          (q_en),
    .sample          (sample_ext),
    .last_stage      (q_last),
    .last_stage_next (q_next)
  );

  // Value each final integrator holds once this cycle's update lands. On the
  // decimating edge only Q is updating, so I contributes its current value.
  assign i_post = i_en ? i_next : i_last;
  assign q_post = q_en ? q_next : q_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt <= '0;
      snap_i  <= '0;
      snap_q  <= '0;
    end else begin
      if (q_en) begin
        dec_cnt <= dec_cnt + RBITS'(1);
      end
      if (dec_edge) begin
        snap_i <= i_post;
        snap_q <= q_post;
      end
    end
  end

  // Output sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dec_edge) state_next = COMB_I;
      COMB_I:  state_next = COMB_Q;
      COMB_Q:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shared comb datapath: one difference stage per integrator stage,
  // differential delay of one decimated sample.
  logic [ACC_W-1:0] dly_i    [N_STAGES];
  logic [ACC_W-1:0] dly_q    [N_STAGES];
  logic [ACC_W-1:0] stage_in [N_STAGES];
  logic [ACC_W-1:0] comb_acc;
  logic [DW-1:0]    comb_scaled;
  logic             sel_q;

  assign sel_q = (state == COMB_Q);

  always_comb begin
    comb_acc = sel_q ? snap_q : snap_i;
    for (int k = 0; k < N_STAGES; k++) begin
      stage_in[k] = comb_acc;
      comb_acc    = comb_acc - (sel_q ? dly_q[k] : dly_i[k]);
    end
    // The top DW bits are the arithmetic right shift by SHIFT truncated to
    // DW bits; this divides out the R**N_STAGES DC gain exactly.
    comb_scaled = comb_acc[ACC_W-1 -: DW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_STAGES; k++) begin
        dly_i[k] <= '0;
        dly_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_STAGES; k++) begin
        if (state == COMB_I) dly_i[k] <= stage_in[k];
        if (state == COMB_Q) dly_q[k] <= stage_in[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else begin
      case (state)
        COMB_I: begin
          data_o  <= comb_scaled;
          valid_o <= 1'b1;
          last_o  <= 1'b0;
        end
        COMB_Q: begin
          data_o  <= comb_scaled;
          valid_o <= 1'b1;
          last_o  <= 1'b1;
        end
        default: begin
          valid_o <= 1'b0;
          last_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iq_cic_decimator.sv
// Self-checking bench for iq_cic_decimator (DW=16, N_STAGES=3, RBITS=2).
// Reference: each channel's final integrator after c samples equals
// sum_j C(c-1-j, N-1) * x[j]; each decimated output is the N-th backward
// difference of those snapshots, taken modulo 2**ACC_W and scaled by
// 2**-(N*RBITS).
module tb_iq_cic_decimator;

  localparam int DW    = 16;
  localparam int N     = 3;
  localparam int RB    = 2;
  localparam int R     = 4;
  localparam int ACC_W = DW + N * RB;
  localparam int SH    = N * RB;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          last_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          last_o;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  iq_cic_decimator #(
    .DW       (DW),
    .N_STAGES (N),
    .RBITS    (RB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .last_i  (last_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .last_o  (last_o)
  );

  // ---------------- scoreboard / model ----------------
  int checks   = 0;
  int failures = 0;
  int n_out    = 0;

  logic [DW:0] exp_q[$];   // {last, data}
  int          due_q[$];   // cycle on which each entry must be visible

  longint i_smp[$], q_smp[$];
  longint i_snap[$], q_snap[$];
  int     q_count = 0;

  function automatic longint binom(input longint n, input int k);
    longint r;
    if (n < k) return 0;
    r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic longint chain_value(input bit is_q);
    longint acc = 0;
    int     c;
    c = is_q ? q_smp.size() : i_smp.size();
    for (int j = 0; j < c; j++) begin
      if (is_q) acc += binom(c - 1 - j, N - 1) * q_smp[j];
      else      acc += binom(c - 1 - j, N - 1) * i_smp[j];
    end
    return acc;
  endfunction

  function automatic logic [DW-1:0] expected_out(input bit is_q);
    longint      acc = 0;
    longint      s;
    int          m;
    logic [63:0] bits;
    m = is_q ? q_snap.size() - 1 : i_snap.size() - 1;
    for (int i = 0; i <= N; i++) begin
      if (m - i >= 0) begin
        s = is_q ? q_snap[m-i] : i_snap[m-i];
        if (i % 2 == 1) acc -= binom(N, i) * s;
        else            acc += binom(N, i) * s;
      end
    end
    bits = acc;
    return bits[ACC_W-1:SH];
  endfunction

  function automatic void model_clear();
    i_smp.delete();  q_smp.delete();
    i_snap.delete(); q_snap.delete();
    exp_q.delete();  due_q.delete();
    q_count = 0;
    n_out   = 0;
  endfunction

  // Called while driving the sample that the DUT captures on the next edge.
  function automatic void model_edge();
    i_snap.push_back(chain_value(1'b0));
    q_snap.push_back(chain_value(1'b1));
    exp_q.push_back({1'b0, expected_out(1'b0)});
    due_q.push_back(cyc + 2);
    exp_q.push_back({1'b1, expected_out(1'b1)});
    due_q.push_back(cyc + 3);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && valid_o) begin
      logic [DW:0] e;
      int          d;
      n_out++;
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_valid observed last=%0b data=%0d expected no output", last_o, $signed(data_o));
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        checks++;
        assert ({last_o, data_o} === e) else begin
          failures++;
          $error("FAIL out_sample observed last=%0b data=%0d expected last=%0b data=%0d",
                 last_o, $signed(data_o), e[DW], $signed(e[DW-1:0]));
        end
        checks++;
        assert (cyc === d) else begin
          failures++;
          $error("FAIL out_timing observed cycle=%0d expected cycle=%0d", cyc, d);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [DW-1:0] d, input logic l);
    @(posedge clk);
    #1;
    data_i  = d;
    valid_i = 1'b1;
    last_i  = l;
    if (l) begin
      q_smp.push_back(longint'($signed(d)));
      q_count++;
      if (q_count % R == 0) model_edge();
    end else begin
      i_smp.push_back(longint'($signed(d)));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      last_i  = 1'b0;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    assert ({valid_o, last_o, data_o} === {2'b00, {DW{1'b0}}}) else begin
      failures++;
      $error("FAIL %s observed valid=%0b last=%0b data=%0d expected 0/0/0", tag, valid_o, last_o, $signed(data_o));
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    valid_i = 1'b0;
    last_i  = 1'b0;
    model_clear();
    #1;
    check_zero_outputs("reset_outputs");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    idle(6);
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL %s_missing observed pending=%0d expected 0", tag, exp_q.size());
    end
  endtask

  task automatic check_count(input string tag, input int want);
    checks++;
    assert (n_out === want) else begin
      failures++;
      $error("FAIL %s_count observed %0d expected %0d", tag, n_out, want);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst     = 1'b1;
    data_i  = '0;
    valid_i = 1'b0;
    last_i  = 1'b0;
    #1;
    check_zero_outputs("power_on_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // DC pairs
    repeat (40) begin
      send(16'd1000, 1'b0);
      send(-16'sd1000, 1'b1);
    end
    drain("dc");
    check_count("dc", 20);

    // Full scale, integrators wrap repeatedly
    do_reset();
    repeat (64) begin
      send(16'h7fff, 1'b0);
      send(16'h8000, 1'b1);
    end
    drain("full_scale");
    check_count("full_scale", 32);

    // Mixer cadence I, Q, idle
    do_reset();
    for (int p = 0; p < 8; p++) begin
      send(16'($urandom_range(0, 16'hffff)), 1'b0);
      send(16'($urandom_range(0, 16'hffff)), 1'b1);
      idle(1);
    end
    drain("framing");
    check_count("framing", 4);

    // Two I samples before each Q
    do_reset();
    repeat (8) begin
      send(16'($urandom_range(0, 16'hffff)), 1'b0);
      send(16'($urandom_range(0, 16'hffff)), 1'b0);
      send(16'($urandom_range(0, 16'hffff)), 1'b1);
    end
    drain("mislabel");
    check_count("mislabel", 4);

    // Reset while the I output is on the bus
    do_reset();
    repeat (4) begin
      send(16'd1000, 1'b0);
      send(-16'sd1000, 1'b1);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    begin
      logic [DW:0] e;
      e = exp_q.pop_front();
      void'(due_q.pop_front());
      checks++;
      assert ({valid_o, last_o, data_o} === {1'b1, e}) else begin
        failures++;
        $error("FAIL pre_reset_i observed valid=%0b last=%0b data=%0d expected 1/%0b/%0d",
               valid_o, last_o, $signed(data_o), e[DW], $signed(e[DW-1:0]));
      end
    end
    rst = 1'b1;
    model_clear();
    #1;
    check_zero_outputs("async_reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    check_count("dropped_pair", 0);
    repeat (40) begin
      send(16'd1000, 1'b0);
      send(-16'sd1000, 1'b1);
    end
    drain("dc_after_reset");
    check_count("dc_after_reset", 20);

    // Zero input
    do_reset();
    repeat (100) begin
      send(16'd0, 1'b0);
      send(16'd0, 1'b1);
    end
    drain("zero");
    check_count("zero", 50);

    // Random traffic with gaps and occasional repeated I
    do_reset();
    for (int p = 0; p < 60; p++) begin
      if ($urandom_range(0, 9) == 0) send(16'($urandom_range(0, 16'hffff)), 1'b0);
      send(16'($urandom_range(0, 16'hffff)), 1'b0);
      send(16'($urandom_range(0, 16'hffff)), 1'b1);
      idle($urandom_range(0, 2));
    end
    drain("random");
    check_count("random", 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
